dcs_out_requant: RTL and testbench

- Downstream consumer of the DCSformer result stream.
- Captures one 8-word burst of 32-bit unsigned results and finds its maximum and argmax.
- Derives a block-floating-point shift so that the maximum fits in 8 bits.
- Streams the 8 requantised bytes out on a valid/ready interface, tagged with the shared shift exponent.
- The producer has no backpressure, so the block absorbs a full burst and flags any burst it cannot accept.

---
 rtl/dcs_out_requant.sv | 163 ++++++++++++++++
 tb/tb_dcs_out_requant.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dcs_out_requant.sv
// dcs_out_requant: captures one N_ELEM-word burst of unsigned results, finds max/argmax,
// derives a shared block-floating-point shift so the max fits in OUT_W bits, and streams
// the requantised bytes out on a valid/ready interface.
// Optional feature: define DCS_REQ_ROUND_EN for round-half-up requantisation with
// saturation; the default build truncates.
module dcs_out_requant #(
    parameter int unsigned N_ELEM = 8,
    parameter int unsigned IN_W   = 32,
    parameter int unsigned OUT_W  = 8,
    localparam int unsigned IDX_W = $clog2(N_ELEM)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    input  logic [IN_W-1:0]  s_data,
    input  logic             o_ready,
    input  logic             err_clr,
    output logic             o_valid,
    output logic [OUT_W-1:0] o_data,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_last,
    output logic [4:0]       o_shift,
    output logic [IDX_W-1:0] o_argmax,
    output logic             busy,
    output logic             err_ovf
);

    typedef enum logic [1:0] {StIdle, StCapt, StNorm, StSend} state_e;

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_ELEM - 1);

    state_e           r_state;
    state_e           w_state_d;
    logic [IN_W-1:0]  r_buf [N_ELEM];
    logic [IN_W-1:0]  r_max;
    logic [IDX_W-1:0] r_argmax;
    logic [IDX_W-1:0] r_argmax_out;
    logic [IDX_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [4:0]       r_shift;
    logic             r_err;
    logic [4:0]       w_shift;
    logic [IN_W-1:0]  w_elem;
    logic [OUT_W-1:0] w_req;
    logic             w_send;
    logic             w_drop;

    assign w_send = (r_state == StSend);
    // Producer cannot be stalled: anything arriving while the buffer is committed is lost.
    assign w_drop = s_valid && ((r_state == StNorm) || (r_state == StSend));
    assign w_elem = r_buf[r_idx];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: if (s_valid) w_state_d = StCapt;
            StCapt: if (s_valid && (r_cnt == LastIdx)) w_state_d = StNorm;
            StNorm: w_state_d = StSend;
            StSend: if (o_ready && (r_idx == LastIdx)) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Shift = MSB position of max minus (OUT_W-1), or 0 if max already fits.
    always_comb begin
        w_shift = '0;
        for (int i = OUT_W; i < IN_W; i++) begin
            if (r_max[i]) w_shift = 5'(i - (OUT_W - 1));
        end
    end

`ifdef DCS_REQ_ROUND_EN
    logic [IN_W:0] w_half;
    logic [IN_W:0] w_sum;
    logic [IN_W:0] w_rnd;

    // Round half up; the extra sum bit catches carry-out, then saturate.
    always_comb begin
        w_half = (r_shift == 5'd0) ? '0 : ((IN_W + 1)'(1) << (r_shift - 5'd1));
        w_sum  = {1'b0, w_elem} + w_half;
        w_rnd  = w_sum >> r_shift;
        w_req  = (|w_rnd[IN_W:OUT_W]) ? '1 : w_rnd[OUT_W-1:0];
    end
`else
    // Plain truncation; every element <= max fits after the shift.
    always_comb begin
        w_req = OUT_W'(w_elem >> r_shift);
    end
`endif

    // Capture buffer, running max/argmax, shift latch and output index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ELEM; i++) r_buf[i] <= '0;
            r_max        <= '0;
            r_argmax     <= '0;
            r_argmax_out <= '0;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_shift      <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (s_valid) begin
                        r_buf[0] <= s_data;
                        r_max    <= s_data;
                        r_argmax <= '0;
                        r_cnt    <= IDX_W'(1);
                    end
                end
                StCapt: begin
                    if (s_valid) begin
                        r_buf[r_cnt] <= s_data;
                        r_cnt        <= r_cnt + IDX_W'(1);
                        // Strict compare keeps the lowest index on ties.
                        if (s_data > r_max) begin
                            r_max    <= s_data;
                            r_argmax <= r_cnt;
                        end
                    end
                end
                StNorm: begin
                    r_shift      <= w_shift;
                    r_argmax_out <= r_argmax;
                    r_idx        <= '0;
                end
                StSend: begin
                    if (o_ready) r_idx <= (r_idx == LastIdx) ? '0 : r_idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Sticky overflow flag; a new drop wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= (r_err && !err_clr) || w_drop;
        end
    end

    assign o_valid  = w_send;
    assign o_data   = w_send ? w_req : '0;
    assign o_idx    = r_idx;
    assign o_last   = w_send && (r_idx == LastIdx);
    assign o_shift  = r_shift;
    assign o_argmax = r_argmax_out;
    assign busy     = (r_state != StIdle);
    assign err_ovf  = r_err;

endmodule

// File: tb/tb_dcs_out_requant.sv
// Testbench for dcs_out_requant: directed and randomized bursts checked against a
// behavioural model of max/argmax/shift/requant. Honours DCS_REQ_ROUND_EN like the DUT.
module tb_dcs_out_requant;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic [31:0] s_data;
    logic        o_ready;
    logic        err_clr;
    logic        o_valid;
    logic [7:0]  o_data;
    logic [2:0]  o_idx;
    logic        o_last;
    logic [4:0]  o_shift;
    logic [2:0]  o_argmax;
    logic        busy;
    logic        err_ovf;

    int checks = 0;
    int errors = 0;
    logic [31:0] burst [8];
    int pat [6] = '{1, 0, 0, 1, 0, 1};

    dcs_out_requant dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .o_ready  (o_ready),
        .err_clr  (err_clr),
        .o_valid  (o_valid),
        .o_data   (o_data),
        .o_idx    (o_idx),
        .o_last   (o_last),
        .o_shift  (o_shift),
        .o_argmax (o_argmax),
        .busy     (busy),
        .err_ovf  (err_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Model: smallest shift that makes the max fit in a byte.
    function automatic int m_shift();
        longint unsigned m = 0;
        int s = 0;
        for (int i = 0; i < 8; i++) if (burst[i] > m) m = burst[i];
        while ((m >> s) > 255) s++;
        return s;
    endfunction

    function automatic int m_argmax();
        int a = 0;
        for (int i = 1; i < 8; i++) if (burst[i] > burst[a]) a = i;
        return a;
    endfunction

    function automatic int m_byte(input logic [31:0] x, input int s);
        longint unsigned v = x;
`ifdef DCS_REQ_ROUND_EN
        if (s > 0) v = v + (64'd1 << (s - 1));
        v = v >> s;
        if (v > 255) v = 255;
`else
        v = v >> s;
`endif
        return int'(v);
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, o_valid, 0);
        chk({tag, "_data"}, o_data, 0);
        chk({tag, "_idx"}, o_idx, 0);
        chk({tag, "_last"}, o_last, 0);
        chk({tag, "_shift"}, o_shift, 0);
        chk({tag, "_argmax"}, o_argmax, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err_ovf, 0);
    endtask

    // Drive the burst (optionally with gaps), then check the NORM-cycle latency.
    task automatic drive_burst(input bit gaps);
        for (int i = 0; i < 8; i++) begin
            if (gaps) begin
                int k = $urandom_range(0, 2);
                repeat (k) begin
                    s_valid = 1'b0;
                    @(negedge clk);
                end
            end
            s_valid = 1'b1;
            s_data  = burst[i];
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_data  = '0;
        chk("norm_valid_low", o_valid, 0);
        chk("norm_busy", busy, 1);
        @(negedge clk);
    endtask

    // Consume `take` bytes; mode 0 ready=1, 1 fixed stall pattern, 2 random.
    task automatic drain(input int mode, input int take, input bit inject);
        int s = m_shift();
        int a = m_argmax();
        int n = 0;
        int cyc = 0;
        while (n < take && cyc < 100) begin
            int r = (mode == 0) ? 1 : (mode == 1) ? pat[cyc % 6] : int'($urandom_range(0, 1));
            o_ready = r[0];
            s_valid = inject && (cyc == 0 || $urandom_range(0, 1) == 1);
            s_data  = $urandom;
            chk("send_valid", o_valid, 1);
            chk("send_data", o_data, m_byte(burst[n], s));
            chk("send_idx", o_idx, n);
            chk("send_last", o_last, (n == 7) ? 1 : 0);
            chk("send_shift", o_shift, s);
            chk("send_argmax", o_argmax, a);
            if (r != 0) n++;
            cyc++;
            @(negedge clk);
        end
        o_ready = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        if (cyc >= 100) chk("drain_timeout", n, take);
        if (take == 8) begin
            chk("post_valid", o_valid, 0);
            chk("post_data", o_data, 0);
            chk("post_idx", o_idx, 0);
            chk("post_last", o_last, 0);
            chk("post_busy", busy, 0);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 8; i++) burst[i] = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) burst[$urandom_range(4, 7)] = burst[$urandom_range(0, 3)];
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        o_ready = 1'b0;
        err_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Ascending 1..8, contiguous, always ready.
        for (int i = 0; i < 8; i++) burst[i] = i + 1;
        drive_burst(0);
        drain(0, 8, 0);

        // Tie on max keeps lowest index; shift 2.
        burst = '{1000, 7, 0, 300, 1000, 5, 6, 2};
        drive_burst(0);
        drain(0, 8, 0);

        // Max 511: shift 1, saturation under rounding.
        burst = '{3, 511, 100, 0, 256, 1, 2, 510};
        drive_burst(1);
        drain(2, 8, 0);

        // Stall pattern on o_ready.
        fill_random();
        drive_burst(0);
        drain(1, 8, 0);
        chk("no_ovf_yet", err_ovf, 0);

        // Second burst arriving during stalled SEND is dropped and flagged.
        fill_random();
        drive_burst(0);
        drain(1, 8, 1);
        chk("ovf_set", err_ovf, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("ovf_clr", err_ovf, 0);
        fill_random();
        drive_burst(1);
        drain(0, 8, 0);

        // All-zero burst, then reset mid-SEND.
        for (int i = 0; i < 8; i++) burst[i] = 0;
        drive_burst(0);
        drain(1, 3, 0);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) burst[i] = i + 1;
        drive_burst(0);
        drain(0, 8, 0);

        // Randomized bursts.
        for (int t = 0; t < 8; t++) begin
            fill_random();
            drive_burst(1);
            drain(2, 8, 0);
        end
        chk("final_err", err_ovf, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
